dsp_mac_pipe: RTL and testbench

- Parametrised, signed pre-add/multiply/accumulate slice with a valid/ready handshake and a fully pipelined datapath (3 register stages).
- Successor to the fixed 18x18/48-bit DSP slice. Adds configurable operand widths, per-sample mode fields that travel with the data, and output backpressure.
- Also adds optional saturation with an overflow flag, and masked pattern detect on the result.
- Sits between sample sources (filter taps, coefficient ROMs) and downstream accumulation/scaling logic.

---
 rtl/dsp_mac_pipe.sv | 184 ++++++++++++++++++
 tb/tb_dsp_mac_pipe.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_pipe.sv
// -----------------------------------------------------------------------------
// dsp_mac_pipe
//   Signed pre-add / multiply / accumulate slice. It has three register stages
//   and a valid/ready handshake. The mode fields travel down the pipe with
//   their sample. Downstream backpressure freezes the whole pipe.
//
//   Stage 1 : operand and mode capture
//   Stage 2 : pre-adder (BW+1 bits) and multiplier -> M (AW+BW+1 bits)
//   Stage 3 : post-adder Z +/- (M + CIN). It saturates or wraps to PW bits.
//
// Ports
//   CLK, RSTN            clock, synchronous active-low reset
//   IN_VALID / IN_READY  input handshake (IN_READY = not stalled)
//   A, B, D, C           signed operands
//   PRE_SEL              00:B 01:D+B 10:D-B 11:B
//   Z_SEL                00:0 01:C 10:P(accumulate) 11:0
//   SUB, CIN             0: Z+M+CIN   1: Z-(M+CIN)
//   OUT_VALID/OUT_READY  output handshake
//   P, OVF               registered result and saturation flag
//   PATDET               masked compare of the registered P against PATTERN
// -----------------------------------------------------------------------------
module dsp_mac_pipe #(
    parameter int            AW      = 18,
    parameter int            BW      = 18,
    parameter int            CW      = 48,
    parameter int            PW      = 48,
    parameter bit            SAT_EN  = 1'b1,
    parameter logic [PW-1:0] PATTERN = '0,
    parameter logic [PW-1:0] MASK    = '0
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [AW-1:0] A,
    input  logic [BW-1:0] B,
    input  logic [BW-1:0] D,
    input  logic [CW-1:0] C,
    input  logic [1:0]    PRE_SEL,
    input  logic [1:0]    Z_SEL,
    input  logic          SUB,
    input  logic          CIN,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [PW-1:0] P,
    output logic          OVF,
    output logic          PATDET
);

    localparam int MW = AW + BW + 1;   // product width
    localparam int SW = PW + 1;        // post-adder width, one guard bit

    logic stall;

    // stage 1
    logic                 v1;
    logic signed [AW-1:0] a1;
    logic signed [BW-1:0] b1, d1;
    logic signed [CW-1:0] c1;
    logic [1:0]           pre_sel1, z_sel1;
    logic                 sub1, cin1;

    // stage 2
    logic                 v2;
    logic signed [MW-1:0] m2;
    logic signed [CW-1:0] c2;
    logic [1:0]           z_sel2;
    logic                 sub2, cin2;

    // stage 3 / outputs
    logic                 out_valid_q;
    logic signed [PW-1:0] p_q;
    logic                 ovf_q;

    // combinational intermediates
    logic signed [BW:0]   b_x, d_x, pre;
    logic signed [MW-1:0] prod;
    logic signed [SW-1:0] m_x, c_x, p_x, cin_x, z, sum;
    logic [PW-1:0]        p_next;
    logic                 ovf_next;

    // A result that is presented but not taken freezes every stage.
    assign stall    = out_valid_q & ~OUT_READY;
    assign IN_READY = ~stall;

    // ---------------- stage 1 ----------------
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value of the one before it.
        if (!RSTN) begin
            v1 <= 1'b0;
        end else if (!stall) begin
            v1 <= IN_VALID;
        end
    end

    // NOTE: pure data registers have no reset; the valid bits alone decide whether their contents are meaningful.
    always_ff @(posedge CLK) begin
        if (!stall && IN_VALID) begin
            a1       <= A;
            b1       <= B;
            d1       <= D;
            c1       <= C;
            pre_sel1 <= PRE_SEL;
            z_sel1   <= Z_SEL;
            sub1     <= SUB;
            cin1     <= CIN;
        end
    end

    // ---------------- stage 2 ----------------
    // The pre-adder gets one extra bit, so D+B and D-B cannot overflow.
    always_comb begin
        b_x = {b1[BW-1], b1};
        d_x = {d1[BW-1], d1};
        case (pre_sel1)
            2'b01:   pre = d_x + b_x;
            2'b10:   pre = d_x - b_x;
            default: pre = b_x;        // 00 and reserved 11
        endcase
        prod = MW'(a1) * MW'(pre);
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            v2 <= 1'b0;
            m2 <= '0;
        end else if (!stall) begin
            v2 <= v1;
            m2 <= prod;
        end
    end

    always_ff @(posedge CLK) begin
        if (!stall) begin
            c2     <= c1;
            z_sel2 <= z_sel1;
            sub2   <= sub1;
            cin2   <= cin1;
        end
    end

    // ---------------- stage 3 ----------------
    always_comb begin
        // NOTE: every variable written here is given a value before any branch, so no path can infer a latch.
        m_x      = SW'(m2);
        c_x      = SW'(c2);
        p_x      = SW'(p_q);
        cin_x    = {{PW{1'b0}}, cin2};
        z        = '0;
        case (z_sel2)
            2'b01:   z = c_x;
            2'b10:   z = p_x;         // latest result, so chained accumulates need no bubble
            default: ;                // 00 and reserved 11 select zero
        endcase
        sum      = sub2 ? (z - m_x - cin_x) : (z + m_x + cin_x);
        p_next   = sum[PW-1:0];
        ovf_next = 1'b0;
        // The guard bit differs from the PW sign bit exactly when the sum is outside the signed PW range.
        if (SAT_EN && (sum[PW] != sum[PW-1])) begin
            ovf_next = 1'b1;
            p_next   = sum[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            out_valid_q <= 1'b0;
            p_q         <= '0;
            ovf_q       <= 1'b0;
        end else if (!stall) begin
            out_valid_q <= v2;
            if (v2) begin
                p_q   <= p_next;
                ovf_q <= ovf_next;
            end
        end
    end

    assign OUT_VALID = out_valid_q;
    assign P         = p_q;
    assign OVF       = ovf_q;
    assign PATDET    = ((p_q ^ PATTERN) & ~MASK) == '0;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// -----------------------------------------------------------------------------
// tb_dsp_mac_pipe
//   Two slices share every input: dut_sat has SAT_EN=1, and dut_wrap has
//   SAT_EN=0 with a masked pattern. A reference model pushes one expected
//   entry per accepted sample. It works on plain 64-bit integers. A monitor
//   pops an entry on every output transfer and compares both slices.
// -----------------------------------------------------------------------------
module tb_dsp_mac_pipe;

    localparam int AW = 18;
    localparam int BW = 18;
    localparam int CW = 48;
    localparam int PW = 48;
    localparam logic [PW-1:0] PAT1  = 48'h0000_0000_0006;
    localparam logic [PW-1:0] MASK1 = 48'hFFFF_FFFF_0000;
    localparam longint MAXP = 64'sd140737488355327;    //  2^47 - 1
    localparam longint MINP = -64'sd140737488355328;   // -2^47

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          IN_VALID = 1'b0;
    logic          OUT_READY = 1'b1;
    logic [AW-1:0] a_in = '0;
    logic [BW-1:0] b_in = '0;
    logic [BW-1:0] d_in = '0;
    logic [CW-1:0] c_in = '0;
    logic [1:0]    pre_sel = '0;
    logic [1:0]    z_sel = '0;
    logic          sub = 1'b0;
    logic          cin = 1'b0;

    logic          in_ready0, in_ready1, out_valid0, out_valid1;
    logic          ovf0, ovf1, patdet0, patdet1;
    logic [PW-1:0] p0, p1;

    always #5 CLK = ~CLK;

    dsp_mac_pipe #(.AW(AW), .BW(BW), .CW(CW), .PW(PW), .SAT_EN(1'b1),
                   .PATTERN('0), .MASK('0)) dut_sat (
        .CLK(CLK), .RSTN(RSTN), .IN_VALID(IN_VALID), .IN_READY(in_ready0),
        .A(a_in), .B(b_in), .D(d_in), .C(c_in), .PRE_SEL(pre_sel), .Z_SEL(z_sel),
        .SUB(sub), .CIN(cin), .OUT_VALID(out_valid0), .OUT_READY(OUT_READY),
        .P(p0), .OVF(ovf0), .PATDET(patdet0));

    dsp_mac_pipe #(.AW(AW), .BW(BW), .CW(CW), .PW(PW), .SAT_EN(1'b0),
                   .PATTERN(PAT1), .MASK(MASK1)) dut_wrap (
        .CLK(CLK), .RSTN(RSTN), .IN_VALID(IN_VALID), .IN_READY(in_ready1),
        .A(a_in), .B(b_in), .D(d_in), .C(c_in), .PRE_SEL(pre_sel), .Z_SEL(z_sel),
        .SUB(sub), .CIN(cin), .OUT_VALID(out_valid1), .OUT_READY(OUT_READY),
        .P(p1), .OVF(ovf1), .PATDET(patdet1));

    typedef struct {
        longint p_sat;
        bit     ovf_sat;
        longint p_wrap;
    } exp_t;

    exp_t   exp_q[$];
    longint log_p[$];
    int     log_c[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc     = 0;
    longint acc_sat  = 0;
    longint acc_wrap = 0;
    bit     force_low = 1'b0;
    bit     rand_bp   = 1'b0;
    bit     mon_en    = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic longint sx(input longint v, input int w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    function automatic longint to_s(input logic [PW-1:0] v);
        return sx(longint'(v), PW);
    endfunction

    function automatic bit pat_hit(input longint p, input logic [PW-1:0] pat, input logic [PW-1:0] msk);
        logic [PW-1:0] pv;
        pv = p[PW-1:0];
        return ((pv ^ pat) & ~msk) == '0;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: arithmetic straight from the slice's rules.
    task automatic model_push(input longint a, input longint b, input longint d, input longint c,
                              input logic [1:0] ps, input logic [1:0] zs, input logic sb, input logic ci);
        longint pre, mc, z, s;
        exp_t   e;
        pre = (ps == 2'b01) ? d + b : (ps == 2'b10) ? d - b : b;
        mc  = a * pre + (ci ? 64'sd1 : 64'sd0);
        z   = (zs == 2'b01) ? c : (zs == 2'b10) ? acc_sat : 0;
        s   = sb ? z - mc : z + mc;
        if (s > MAXP)      begin e.p_sat = MAXP; e.ovf_sat = 1'b1; end
        else if (s < MINP) begin e.p_sat = MINP; e.ovf_sat = 1'b1; end
        else               begin e.p_sat = s;    e.ovf_sat = 1'b0; end
        z   = (zs == 2'b01) ? c : (zs == 2'b10) ? acc_wrap : 0;
        s   = sb ? z - mc : z + mc;
        e.p_wrap = sx(s, PW);
        acc_sat  = e.p_sat;
        acc_wrap = e.p_wrap;
        exp_q.push_back(e);
    endtask

    // Present one sample until it is accepted, then drop IN_VALID after the accept edge.
    task automatic send(input longint a, input longint b, input longint d, input longint c,
                        input logic [1:0] ps, input logic [1:0] zs, input logic sb, input logic ci);
        int tries = 0;
        bit done  = 1'b0;
        while (!done) begin
            @(negedge CLK);
            a_in = a[AW-1:0]; b_in = b[BW-1:0]; d_in = d[BW-1:0]; c_in = c[CW-1:0];
            pre_sel = ps; z_sel = zs; sub = sb; cin = ci;
            IN_VALID = 1'b1;
            #1;
            if (in_ready0) begin
                model_push(a, b, d, c, ps, zs, sb, ci);
                done = 1'b1;
            end else if (++tries > 200) begin
                check("send_timeout", 0, 1);
                done = 1'b1;
            end
        end
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Called right after the accept edge: the result must appear after exactly two more edges.
    task automatic expect_after2(input string nm, input longint p_exp);
        check({nm, "_lat0"}, out_valid0, 0);
        @(posedge CLK); #1;
        check({nm, "_lat1"}, out_valid0, 0);
        @(posedge CLK); #1;
        check({nm, "_valid"}, out_valid0, 1);
        check({nm, "_p"}, to_s(p0), p_exp);
    endtask

    task automatic pulse_reset(input int n);
        @(negedge CLK);
        RSTN = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
        exp_q.delete();
        acc_sat  = 0;
        acc_wrap = 0;
        @(negedge CLK);
        RSTN = 1'b1;
    endtask

    task automatic wait_log(input int target, input string nm);
        int n = 0;
        while (log_p.size() < target && n < 200) begin
            @(negedge CLK); #3;
            n++;
        end
        check(nm, log_p.size(), target);
    endtask

    task automatic stream_1_to_6();
        for (int k = 1; k <= 6; k++) send(k, 1, 0, 0, 2'b00, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic stall_mid(input int base);
        longint p_hold = 0;
        int     n = 0;
        while (log_p.size() < base + 2 && n < 200) begin
            @(negedge CLK); #3;
            n++;
        end
        force_low = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); #2;
            check("bp_in_ready", in_ready0, 0);
            if (i == 0) p_hold = to_s(p0);
            else        check("bp_p_hold", to_s(p0), p_hold);
        end
        force_low = 1'b0;
    endtask

    // Downstream ready: forced low, random, or held high.
    initial begin
        forever begin
            @(negedge CLK);
            OUT_READY = force_low ? 1'b0 : (rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // Monitor / scoreboard: a transfer happens at the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK); #2;
            if (mon_en && out_valid0 === 1'b1 && OUT_READY === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_p_sat",     to_s(p0), e.p_sat);
                    check("sb_ovf_sat",   ovf0, e.ovf_sat);
                    check("sb_pat_sat",   patdet0, pat_hit(e.p_sat, '0, '0));
                    check("sb_valid_wrap", out_valid1, 1);
                    check("sb_p_wrap",    to_s(p1), e.p_wrap);
                    check("sb_ovf_wrap",  ovf1, 0);
                    check("sb_pat_wrap",  patdet1, pat_hit(e.p_wrap, PAT1, MASK1));
                    log_p.push_back(to_s(p0));
                    log_c.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        longint ra, rb, rd, rc;
        int     base, n;

        // Reset with IN_VALID high for two edges.
        RSTN = 1'b0;
        IN_VALID = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_out_valid", out_valid0, 0);
        check("rst_p",         to_s(p0), 0);
        check("rst_patdet",    patdet0, 1);
        check("rst_in_ready",  in_ready0, 1);
        @(negedge CLK);
        RSTN = 1'b1;
        IN_VALID = 1'b0;
        mon_en = 1'b1;
        idle(1);
        check("post_rst_out_valid", out_valid0, 0);
        check("post_rst_in_ready",  in_ready0, 1);

        // Pre-add multiply: 3*(10+4)+5+1 = 48, then 100-(3*(10-4)+1) = 81.
        send(3, 4, 10, 5, 2'b01, 2'b01, 1'b0, 1'b1);
        expect_after2("preadd_add", 48);
        send(3, 4, 10, 100, 2'b10, 2'b01, 1'b1, 1'b1);
        expect_after2("preadd_sub", 81);

        // Accumulate streaming from a fresh reset.
        idle(2);
        pulse_reset(1);
        base = log_p.size();
        for (int i = 0; i < 4; i++) send(2, 3, 0, 0, 2'b00, 2'b10, 1'b0, 1'b0);
        wait_log(base + 4, "acc_count");
        for (int i = 0; i < 4; i++) check("acc_value", log_p[base + i], 6 * (i + 1));
        for (int i = 1; i < 4; i++) check("acc_no_bubble", log_c[base + i] - log_c[base + i - 1], 1);

        // Backpressure mid-stream.
        idle(3);
        base = log_p.size();
        fork
            stream_1_to_6();
            stall_mid(base);
        join
        wait_log(base + 6, "bp_count");
        for (int k = 1; k <= 6; k++) check("bp_order", log_p[base + k - 1], k);
        idle(5);
        check("bp_no_dup", log_p.size(), base + 6);

        // Saturation versus wrap.
        idle(3);
        send(1, 1, 0, MAXP, 2'b00, 2'b01, 1'b0, 1'b0);
        expect_after2("sat", MAXP);
        check("sat_ovf",    ovf0, 1);
        check("wrap_p",     to_s(p1), MINP);
        check("wrap_ovf",   ovf1, 0);

        // Mid-operation reset discards in-flight samples.
        idle(3);
        base = log_p.size();
        send(2, 3, 0, 0, 2'b00, 2'b10, 1'b0, 1'b0);
        send(2, 3, 0, 0, 2'b00, 2'b10, 1'b0, 1'b0);
        pulse_reset(1);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK); #2;
            check("midrst_no_out", out_valid0, 0);
        end
        check("midrst_log", log_p.size(), base);
        send(2, 3, 0, 0, 2'b00, 2'b10, 1'b0, 1'b0);
        expect_after2("midrst_acc", 6);

        // Randomised traffic with random backpressure.
        idle(2);
        rand_bp = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                ra = sx(longint'($urandom), AW);
                rb = sx(longint'($urandom), BW);
                rd = sx(longint'($urandom), BW);
                rc = {$urandom, $urandom};
                rc = ($urandom_range(0, 1) == 0) ? sx(rc, CW) : sx(rc, 20);
                send(ra, rb, rd, rc, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end
        rand_bp = 1'b0;
        n = 0;
        while (exp_q.size() > 0 && n < 500) begin
            @(negedge CLK); #3;
            n++;
        end
        check("drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
